// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   INSTR_BYTES   : bytes per instruction word (pc step per fetch)
//   NOP_INSTR     : canonical RV32 NOP encoding (addi x0, x0, 0)
//   fetch_entry_t : one buffered fetch result {pc, instr} at the default 32-bit width
//   ptr_width()   : pointer width for a power-of-two buffer depth
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's bus signals.
//   imem_addr / imem_rdata      : instruction memory request / registered response
//   redirect_valid / redirect_pc: branch/jump redirect from the back end
//   out_valid / out_ready       : delivery handshake toward decode
//   out_instr / out_pc          : instruction at buffer head and its address
//   fetch_count                 : instructions delivered since reset
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fetch_count
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, instr} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all entries (wins over push/pop)
//   push/push_data : write an entry at the tail
//   pop        : drop the head entry
//   head       : entry at the head (meaningful only when count != 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    // Guards keep the buffer consistent even if a caller misbehaves; a push into a
    // full buffer is only accepted when the head leaves on the same edge.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != (PTR_W + 1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch with a small decoupling buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_unit_if.master (imem request/response, redirect,
//                out_valid/out_ready delivery, fetch_count)
// One fetch may be in flight at a time; memory returns data one edge after the
// address is presented. A fetch is only issued when the buffer has room for it
// counting the word already in flight, so the buffer can never overflow.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]  pc_q;
    logic             inflight_q;
    logic [XLEN-1:0]  inflight_pc_q;
    logic [31:0]      fetch_count_q;

    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           push_data;
    logic             out_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = inflight_q && !bus.redirect_valid;

    // Entries held after this edge plus the one in flight; pop can only be set
    // when count is non-zero, so this never underflows.
    assign occupancy = {1'b0, count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(inflight_q);
    assign issue     = !bus.redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));

    assign push_data.pc    = inflight_pc_q;
    assign push_data.instr = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop && !bus.redirect_valid),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fetch_count_q <= '0;
        end else if (bus.redirect_valid) begin
            // The returning word (if any) belongs to the old path and is dropped.
            pc_q       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            if (issue) begin
                pc_q          <= pc_q + XLEN'(INSTR_BYTES);
                inflight_pc_q <= pc_q;
                inflight_q    <= 1'b1;
            end else if (push) begin
                inflight_q <= 1'b0;
            end
            if (pop) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? head.instr : '0;
    assign bus.out_pc      = out_valid ? head.pc : '0;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard: stimulus queues the
// expected {pc, instr, fetch_count} of each delivery, a negedge monitor pops and
// compares on every accepted handshake. Memory returns word == address.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory: data for an address appears one edge later.
    always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] fc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc;
        e.fc    = fc;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a handshake coinciding with a redirect is not a delivery.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h expected none", bus.out_pc);
            end else begin
                mon_e = sb.pop_front();
                check("deliver_pc", bus.out_pc, mon_e.pc);
                check("deliver_instr", bus.out_instr, mon_e.instr);
                check("deliver_fetch_count", bus.fetch_count, mon_e.fc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #12;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_out_pc", bus.out_pc, 32'h0);
        check("reset_out_instr", bus.out_instr, 32'h0);
        check("reset_imem_addr", bus.imem_addr, 32'h0);
        check("reset_fetch_count", bus.fetch_count, 32'd0);

        // Streaming from reset with out_ready held high.
        for (int i = 0; i < 5; i++) expect_word(32'(4 * i), 32'(i));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("latency_edge1_valid", {31'b0, bus.out_valid}, 32'd0);
        check("issue_edge1_addr", bus.imem_addr, 32'h4);
        step(1);
        check("latency_edge2_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
        end
        step(1);
        bus.out_ready = 1'b0;

        // Fresh reset with out_ready low: buffer fills to DEPTH and fetch stalls.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_fetch_count", bus.fetch_count, 32'd0);
        for (int i = 0; i < 4; i++) expect_word(32'(4 * i), 32'(i));
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        check("stall_addr_e5", bus.imem_addr, 32'h10);
        step(5);
        check("stall_addr_e10", bus.imem_addr, 32'h10);
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        step(4);

        // Buffer now holds 3 entries with one in flight; redirect to 0x103.
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        expect_word(32'h100, 32'd4);
        expect_word(32'h104, 32'd5);
        step(1);
        bus.redirect_valid = 1'b0;
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("redirect_addr", bus.imem_addr, 32'h100);
        check("flush_fetch_count", bus.fetch_count, 32'd4);
        bus.out_ready = 1'b1;
        step(4);

        // Redirect coinciding with a valid pop (head 0x108).
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        expect_word(32'h200, 32'd6);
        expect_word(32'h204, 32'd7);
        step(1);
        bus.redirect_valid = 1'b0;
        check("popredir_fetch_count", bus.fetch_count, 32'd6);
        check("popredir_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("popredir_addr", bus.imem_addr, 32'h200);
        step(4);

        // Back-to-back redirects: the second target wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        step(1);
        bus.redirect_pc    = 32'h0000_0400;
        step(1);
        bus.redirect_valid = 1'b0;
        check("b2b_addr", bus.imem_addr, 32'h400);
        check("b2b_fetch_count", bus.fetch_count, 32'd8);
        expect_word(32'h400, 32'd8);
        expect_word(32'h404, 32'd9);
        step(3);

        // Asynchronous reset pulse between edges.
        step(1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_rst_fetch_count", bus.fetch_count, 32'd0);
        check("async_rst_addr", bus.imem_addr, 32'h0);
        check("async_rst_out_instr", bus.out_instr, 32'h0);
        #1;
        rst_n = 1'b1;
        expect_word(32'h0, 32'd0);
        expect_word(32'h4, 32'd1);
        step(4);

        // Wrap of pc past the top of the address space; low bits of target ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        expect_word(32'hFFFF_FFFC, 32'd2);
        expect_word(32'h0000_0000, 32'd3);
        step(1);
        bus.redirect_valid = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_fetch_count", bus.fetch_count, 32'd2);
        step(4);
        bus.out_ready = 1'b0;
        step(3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, sets address/instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, sets the instruction buffer entry count (power of 2, >=2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  XLEN  byte address to instruction memory (memory registers output, data valid one cycle later).
REQ-007 imem_rdata  in  XLEN  instruction word for the address presented on the previous edge.
REQ-008 redirect_valid  in  1  branch/jump redirect strobe.
REQ-009 redirect_pc  in  XLEN  redirect target; bits [1:0] ignored.
REQ-010 out_valid  out  1  buffered instruction available.
REQ-011 out_ready  in  1  consumer accepts instruction.
REQ-012 out_instr  out  XLEN  instruction at buffer head.
REQ-013 out_pc  out  XLEN  address of out_instr.
REQ-014 fetch_count  out  32  number of instructions delivered (out_valid & out_ready) since reset; wraps at 2^32.

Function
REQ-015 imem_addr SHALL equal the pc register combinationally; pc increments by 4 per issued fetch, wrapping modulo 2^XLEN.
REQ-016 Issue SHALL occur on an edge when no redirect and (count - pop + inflight) < DEPTH, where pop = out_valid & out_ready; issue sets inflight=1, inflight_pc=pc, pc=pc+4.
REQ-017 On an edge with inflight=1 and no redirect, {inflight_pc, imem_rdata} SHALL be pushed into the buffer; inflight clears unless a new issue occurs the same edge.
REQ-018 The buffer SHALL never overflow; push and pop on the same edge leave count unchanged.
REQ-019 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL reflect the head entry and be stable while out_valid & !out_ready.
REQ-020 Latency SHALL be two edges from issue to out_valid; with out_ready held high throughput SHALL be one instruction per cycle.
REQ-021 Redirect SHALL take priority over all other events: on that edge buffer is flushed (count=0), inflight cleared (returning word discarded), pop ignored, fetch_count not incremented, pc=redirect_pc & ~3, no issue.
REQ-022 Fetch resumes at the edge following a redirect; back-to-back redirects each override the prior target.
REQ-023 With out_ready low, fetch SHALL stall once DEPTH entries are buffered or reserved; pc holds.

Reset
REQ-024 While rst_n=0: pc=RESET_PC, inflight=0, count=0, read/write pointers=0, fetch_count=0, out_valid=0, out_instr=0, out_pc=0.
REQ-025 Reset assertion mid-operation SHALL discard all buffered and in-flight instructions immediately, independent of clk.
REQ-026 First issue of RESET_PC SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package fetch_pkg SHALL hold INSTR_BYTES=4, the NOP encoding 32'h0000_0013, and the buffer-entry struct {pc, instr}.
REQ-028 Buffer SHALL be a separate sub-module fetch_fifo (DEPTH entries, push/pop/flush, count output).
REQ-029 Pointer width SHALL be $clog2(DEPTH); count width $clog2(DEPTH)+1.

Verification
REQ-030 Reset release, out_ready=1, memory word = address -> out_pc/out_instr 0,4,8,12,16 on consecutive cycles, first out_valid two edges after release.
REQ-031 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, imem_addr holds 0x10, no lost/duplicated word on out_ready=1.
REQ-032 Redirect to 0x103 while buffer holds 3 entries and one in flight -> next out_pc=0x100, no stale words delivered, fetch_count unchanged by flushed entries.
REQ-033 Redirect coincident with pop -> pop ignored, fetch_count not incremented, next delivered out_pc = redirect target.
REQ-034 rst_n pulsed low mid-stream (between edges) -> out_valid=0 immediately; resume from RESET_PC, fetch_count=0.
REQ-035 pc=0xFFFF_FFFC with out_ready=1 -> out_pc sequence 0xFFFF_FFFC, 0x0000_0000 (wrap).
